car_parking_ctrl: RTL and testbench
===================================

CAR_PARKING_CTRL -- requirements
Module: car_parking_ctrl

Interface
REQ-001 Parameter N_SLOTS, default 8: number of parking slots, 2..64.
REQ-002 Parameter CODE_W, default 8: ticket/exit code width, 4..16.
REQ-003 Parameter MAX_FAIL, default 3: consecutive bad exit attempts before lockout, 1..15.
REQ-004 Derived SLOT_W = clog2(N_SLOTS), min 1.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 car_arrive  in  1  arrival request level; rising edge is one request.
REQ-008 car_exit  in  1  exit request level; rising edge is one request.
REQ-009 exit_from  in  SLOT_W  slot claimed by exiting car, sampled on car_exit edge.
REQ-010 exit_code  in  CODE_W  ticket presented by exiting car, sampled on car_exit edge.
REQ-011 alarm_clr  in  1  attendant clear of lockout, level.
REQ-012 park_valid  out  1  one-cycle pulse: slot granted.
REQ-013 parking_slot  out  SLOT_W  granted slot index, held until next grant.
REQ-014 ticket_code  out  CODE_W  code issued with grant, held until next grant.
REQ-015 can_park  out  1  at least one free slot and not locked.
REQ-016 exit_ok  out  1  one-cycle pulse: exit accepted.
REQ-017 exit_err  out  1  one-cycle pulse: exit rejected.
REQ-018 alarm  out  1  lockout active.
REQ-019 occupancy  out  SLOT_W+1  count of occupied slots.
REQ-020 parking_register  out  N_SLOTS  bit i = 1 when slot i occupied.

Function
REQ-021 Requests: edge detect = input high now, low in previous registered sample; held levels issue no repeat requests.
REQ-022 Arrival edge with can_park=1: lowest-index free slot marked occupied, its code stored, park_valid/parking_slot/ticket_code update on the next edge (latency 1 cycle).
REQ-023 Arrival edge with can_park=0: ignored, no pulse, no state change.
REQ-024 Code source: CODE_W-bit maximal-length Galois LFSR, seed 1, advances every cycle; issued code = current LFSR value, never 0.
REQ-025 Exit edge: exit_ok when exit_from < N_SLOTS, slot occupied, exit_code equals stored code; slot freed, fail counter cleared, pulse 1 cycle later.
REQ-026 Any other exit edge: exit_err pulse 1 cycle later, slot state unchanged, fail counter +1 (saturating at MAX_FAIL).
REQ-027 FSM states RUN, LOCK; RUN->LOCK when fail counter reaches MAX_FAIL; LOCK->RUN when alarm_clr=1, clearing fail counter.
REQ-028 In LOCK: arrival and exit edges ignored (no pulses), alarm=1, can_park=0, occupancy/register frozen.
REQ-029 Simultaneous arrival and exit edges in one cycle: both processed; allocation uses the pre-cycle register, so a slot freed this cycle is not re-granted this cycle.
REQ-030 Full (occupancy = N_SLOTS) plus simultaneous valid exit: arrival rejected, exit accepted, can_park=1 next cycle.
REQ-031 occupancy = population count of parking_register at all times; never exceeds N_SLOTS, never wraps below 0.
REQ-032 can_park is registered-state combinational: (occupancy < N_SLOTS) and state = RUN.

Reset
REQ-033 rst=0 asynchronously: parking_register=0, occupancy=0, stored codes=0, LFSR=1, fail counter=0, state=RUN, edge-detect history=0.
REQ-034 During reset: park_valid=0, exit_ok=0, exit_err=0, alarm=0, parking_slot=0, ticket_code=0, can_park=1 after release.
REQ-035 Reset mid-operation discards in-flight pulses; first request edge is recognised no earlier than the second clock after release.

Structure
REQ-036 Shared package car_parking_pkg holds FSM state typedef (RUN, LOCK), LFSR tap constants per CODE_W, default parameter values.
REQ-037 Sub-module free_slot_finder: N_SLOTS-wide lowest-zero priority encoder, outputs index and any_free.

Verification
REQ-038 Reset then 3 arrival pulses -> park_valid x3, slots 0,1,2, parking_register=8'h07, occupancy=3.
REQ-039 Car at slot 1 exits with issued ticket_code -> exit_ok, register=8'h05; next arrival -> slot 1.
REQ-040 Fill 8 slots, 9th arrival -> no park_valid, can_park=0; same-cycle arrival + valid exit of slot 4 -> exit_ok only, can_park=1 next cycle.
REQ-041 Three wrong codes on slot 2 -> exit_err x3, alarm=1; correct code then ignored; alarm_clr=1 -> alarm=0, correct code -> exit_ok.
REQ-042 exit_from=2 on empty slot with code 15 -> exit_err, register unchanged; car_arrive held high 10 cycles -> exactly one grant.
REQ-043 rst low between arrival edge and grant -> no park_valid, register=0, occupancy=0.

Source files
------------

// File: rtl/car_parking_pkg.sv
// Shared types and constants for the parking controller.
//   park_state_e : controller mode (RUN / LOCK)
//   DEF_*        : default parameter values
//   lfsr_taps()  : Galois feedback mask for a maximal-length LFSR of width 4..16
package car_parking_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } park_state_e;

  localparam int unsigned DEF_N_SLOTS  = 8;
  localparam int unsigned DEF_CODE_W   = 8;
  localparam int unsigned DEF_MAX_FAIL = 3;
  localparam int unsigned FAIL_W       = 4;

  // Right-shift Galois feedback masks, one maximal-length polynomial per width.
  function automatic logic [15:0] lfsr_taps(input int unsigned w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      default: return 16'hB400;
    endcase
  endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-index free slot priority encoder.
//   occupied   : slot occupancy bitmap (1 = taken)
//   index_c    : lowest index whose bit is 0 (0 when none free)
//   any_free_c : at least one slot is free
module free_slot_finder #(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned SLOT_W  = 3
) (
  input  logic [N_SLOTS-1:0] occupied,
  output logic [SLOT_W-1:0]  index_c,
  output logic               any_free_c
);

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    index_c    = '0;
    any_free_c = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        index_c    = SLOT_W'(i);
        any_free_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/car_parking_ctrl.sv
// Car park controller: slot allocation with LFSR tickets, ticket-checked
// exits and lockout after repeated bad exit attempts.
//   clk, rst (async, active-low)
//   car_arrive / car_exit    : request levels, rising edge = one request
//   exit_from / exit_code    : claimed slot and ticket, sampled on exit edge
//   alarm_clr                : attendant release of lockout
//   park_valid/parking_slot/ticket_code : grant pulse, held slot and code
//   exit_ok / exit_err       : exit verdict pulses
//   can_park, alarm, occupancy, parking_register : status
module car_parking_ctrl
  import car_parking_pkg::*;
#(
  parameter int unsigned N_SLOTS  = DEF_N_SLOTS,
  parameter int unsigned CODE_W   = DEF_CODE_W,
  parameter int unsigned MAX_FAIL = DEF_MAX_FAIL,
  localparam int unsigned SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               car_arrive,
  input  logic               car_exit,
  input  logic [SLOT_W-1:0]  exit_from,
  input  logic [CODE_W-1:0]  exit_code,
  input  logic               alarm_clr,
  output logic               park_valid,
  output logic [SLOT_W-1:0]  parking_slot,
  output logic [CODE_W-1:0]  ticket_code,
  output logic               can_park,
  output logic               exit_ok,
  output logic               exit_err,
  output logic               alarm,
  output logic [SLOT_W:0]    occupancy,
  output logic [N_SLOTS-1:0] parking_register
);

  localparam logic [CODE_W-1:0] TAPS = CODE_W'(lfsr_taps(CODE_W));
  localparam logic [SLOT_W:0]   FULL = (SLOT_W + 1)'(N_SLOTS);

  park_state_e        state_q, state_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic               ready_q;
  logic               arr_q, ext_q;
  logic [CODE_W-1:0]  lfsr_q, lfsr_d;
  logic [N_SLOTS-1:0] reg_q, reg_d;
  logic [SLOT_W:0]    occ_q, occ_d;
  logic [CODE_W-1:0]  codes_q [N_SLOTS];
  logic               pv_d, ok_d, err_d;
  logic [SLOT_W-1:0]  slot_d;
  logic [CODE_W-1:0]  tick_d;

  logic [SLOT_W-1:0]  free_idx;
  logic               any_free;
  logic               arr_edge, ext_edge, run, from_ok, exit_match, grant, exit_good, exit_bad;

  free_slot_finder #(.N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W)) u_finder (
    .occupied   (reg_q),
    .index_c    (free_idx),
    .any_free_c (any_free)
  );

  // Request qualification; ready_q holds requests off for the first clock after reset.
  assign arr_edge   = car_arrive & ~arr_q & ready_q;
  assign ext_edge   = car_exit & ~ext_q & ready_q;
  assign run        = (state_q == RUN);
  assign from_ok    = ({1'b0, exit_from} < FULL);
  assign exit_match = from_ok && reg_q[exit_from] && (codes_q[exit_from] == exit_code);
  assign grant      = arr_edge & can_park & any_free;
  assign exit_good  = run & ext_edge & exit_match;
  assign exit_bad   = run & ext_edge & ~exit_match;

  assign can_park         = (occ_q < FULL) && run;
  assign alarm            = (state_q == LOCK);
  assign occupancy        = occ_q;
  assign parking_register = reg_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    reg_d   = reg_q;
    occ_d   = occ_q + (SLOT_W + 1)'(grant) - (SLOT_W + 1)'(exit_good);
    pv_d    = grant;
    ok_d    = exit_good;
    err_d   = exit_bad;
    slot_d  = grant ? free_idx : parking_slot;
    tick_d  = grant ? lfsr_q : ticket_code;

    // Allocation reads the pre-cycle bitmap, so a slot freed now is never re-granted now.
    if (grant)     reg_d[free_idx]  = 1'b1;
    if (exit_good) reg_d[exit_from] = 1'b0;

    case (state_q)
      RUN: begin
        if (exit_good) begin
          fail_d = '0;
        end else if (exit_bad) begin
          if (fail_q >= FAIL_W'(MAX_FAIL - 1)) begin
            fail_d  = FAIL_W'(MAX_FAIL);
            state_d = LOCK;
          end else begin
            fail_d = fail_q + FAIL_W'(1);
          end
        end
      end
      LOCK: begin
        if (alarm_clr) begin
          state_d = RUN;
          fail_d  = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      fail_q       <= '0;
      ready_q      <= 1'b0;
      arr_q        <= 1'b0;
      ext_q        <= 1'b0;
      lfsr_q       <= CODE_W'(1);
      reg_q        <= '0;
      occ_q        <= '0;
      park_valid   <= 1'b0;
      exit_ok      <= 1'b0;
      exit_err     <= 1'b0;
      parking_slot <= '0;
      ticket_code  <= '0;
    end else begin
      state_q      <= state_d;
      fail_q       <= fail_d;
      ready_q      <= 1'b1;
      arr_q        <= car_arrive;
      ext_q        <= car_exit;
      lfsr_q       <= lfsr_d;
      reg_q        <= reg_d;
      occ_q        <= occ_d;
      park_valid   <= pv_d;
      exit_ok      <= ok_d;
      exit_err     <= err_d;
      parking_slot <= slot_d;
      ticket_code  <= tick_d;
    end
  end

  // Ticket store, written with the code issued at grant time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SLOTS; i++) codes_q[i] <= '0;
    end else if (grant) begin
      codes_q[free_idx] <= lfsr_q;
    end
  end

endmodule

// File: tb/tb_car_parking_ctrl.sv
// Directed, table-driven bench for car_parking_ctrl (default parameters).
module tb_car_parking_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       car_arrive, car_exit, alarm_clr;
  logic [2:0] exit_from;
  logic [7:0] exit_code;
  logic       park_valid, can_park, exit_ok, exit_err, alarm;
  logic [2:0] parking_slot;
  logic [7:0] ticket_code;
  logic [3:0] occupancy;
  logic [7:0] parking_register;

  int n_chk  = 0;
  int n_fail = 0;

  car_parking_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .car_arrive       (car_arrive),
    .car_exit         (car_exit),
    .exit_from        (exit_from),
    .exit_code        (exit_code),
    .alarm_clr        (alarm_clr),
    .park_valid       (park_valid),
    .parking_slot     (parking_slot),
    .ticket_code      (ticket_code),
    .can_park         (can_park),
    .exit_ok          (exit_ok),
    .exit_err         (exit_err),
    .alarm            (alarm),
    .occupancy        (occupancy),
    .parking_register (parking_register)
  );

  always #5 clk = ~clk;

  // Reference code generator: x^8+x^6+x^5+x^4+1 Galois LFSR, seed 1, steps every clock.
  logic [7:0] m_lfsr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'd1;
    else      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
  end

  typedef struct {
    logic       arr, ex;
    logic [2:0] from;
    int         csel;   // 0: literal code, 1: issued code, 2: issued code with bit 0 flipped
    logic [7:0] code;
    logic       clr;
    logic       pv;
    logic [2:0] slot;
    logic       ok, err, alm;
    logic [7:0] rg;
  } vec_t;

  vec_t       tv[$];
  logic [7:0] mcode [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic arr, input logic ex, input logic [2:0] from, input int csel,
                     input logic [7:0] code, input logic clr, input logic pv, input logic [2:0] slot,
                     input logic ok, input logic err, input logic alm, input logic [7:0] rg);
    vec_t v;
    v.arr = arr; v.ex = ex; v.from = from; v.csel = csel; v.code = code; v.clr = clr;
    v.pv = pv; v.slot = slot; v.ok = ok; v.err = err; v.alm = alm; v.rg = rg;
    tv.push_back(v);
  endtask

  task automatic idle(input logic alm, input logic [7:0] rg);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, alm, rg);
  endtask

  task automatic check_status(input string tag, input logic alm, input logic [7:0] rg);
    chk({tag, " alarm"}, 32'(alarm), 32'(alm));
    chk({tag, " register"}, 32'(parking_register), 32'(rg));
    chk({tag, " occupancy"}, 32'(occupancy), 32'($countones(rg)));
    chk({tag, " can_park"}, 32'(can_park), 32'(($countones(rg) < 8) && !alm));
  endtask

  task automatic build_table();
    // three arrivals fill slots 0..2
    add(1,0,0,0,0,0, 1,0,0,0,0,8'h01); idle(0,8'h01);
    add(1,0,0,0,0,0, 1,1,0,0,0,8'h03); idle(0,8'h03);
    add(1,0,0,0,0,0, 1,2,0,0,0,8'h07); idle(0,8'h07);
    // slot 1 leaves with its ticket, next arrival takes slot 1
    add(0,1,1,1,0,0, 0,0,1,0,0,8'h05); idle(0,8'h05);
    add(1,0,0,0,0,0, 1,1,0,0,0,8'h07); idle(0,8'h07);
    // fill to capacity
    add(1,0,0,0,0,0, 1,3,0,0,0,8'h0F); idle(0,8'h0F);
    add(1,0,0,0,0,0, 1,4,0,0,0,8'h1F); idle(0,8'h1F);
    add(1,0,0,0,0,0, 1,5,0,0,0,8'h3F); idle(0,8'h3F);
    add(1,0,0,0,0,0, 1,6,0,0,0,8'h7F); idle(0,8'h7F);
    add(1,0,0,0,0,0, 1,7,0,0,0,8'hFF); idle(0,8'hFF);
    // full: arrival refused; arrival + valid exit of slot 4 -> only the exit
    add(1,0,0,0,0,0, 0,0,0,0,0,8'hFF); idle(0,8'hFF);
    add(1,1,4,1,0,0, 0,0,1,0,0,8'hEF); idle(0,8'hEF);
    add(1,0,0,0,0,0, 1,4,0,0,0,8'hFF); idle(0,8'hFF);
    // slot freed in the same cycle as an arrival is not the one granted
    add(0,1,5,1,0,0, 0,0,1,0,0,8'hDF); idle(0,8'hDF);
    add(1,1,0,1,0,0, 1,5,1,0,0,8'hFE); idle(0,8'hFE);
    add(1,0,0,0,0,0, 1,0,0,0,0,8'hFF); idle(0,8'hFF);
    // three bad tickets on slot 2 -> lockout
    add(0,1,2,2,0,0, 0,0,0,1,0,8'hFF); idle(0,8'hFF);
    add(0,1,2,2,0,0, 0,0,0,1,0,8'hFF); idle(0,8'hFF);
    add(0,1,2,2,0,0, 0,0,0,1,1,8'hFF); idle(1,8'hFF);
    add(0,1,2,1,0,0, 0,0,0,0,1,8'hFF); idle(1,8'hFF);
    add(1,0,0,0,0,0, 0,0,0,0,1,8'hFF); idle(1,8'hFF);
    add(0,0,0,0,0,1, 0,0,0,0,0,8'hFF); idle(0,8'hFF);
    add(0,1,2,1,0,0, 0,0,1,0,0,8'hFB); idle(0,8'hFB);
    // a good exit clears the fail count
    add(0,1,3,2,0,0, 0,0,0,1,0,8'hFB); idle(0,8'hFB);
    add(0,1,3,2,0,0, 0,0,0,1,0,8'hFB); idle(0,8'hFB);
    add(0,1,3,1,0,0, 0,0,1,0,0,8'hF3); idle(0,8'hF3);
    add(0,1,3,1,0,0, 0,0,0,1,0,8'hF3); idle(0,8'hF3);
    // empty slot with arbitrary code
    add(0,1,2,0,8'd15,0, 0,0,0,1,0,8'hF3); idle(0,8'hF3);
  endtask

  initial begin
    logic [7:0] exp_tk;
    int         n_pv;
    string      tag;

    rst = 1'b0; car_arrive = 0; car_exit = 0; exit_from = 0; exit_code = 0; alarm_clr = 0;
    build_table();

    repeat (2) @(negedge clk);
    chk("reset park_valid", 32'(park_valid), 0);
    chk("reset exit_ok", 32'(exit_ok), 0);
    chk("reset exit_err", 32'(exit_err), 0);
    chk("reset slot", 32'(parking_slot), 0);
    chk("reset ticket", 32'(ticket_code), 0);
    check_status("reset", 0, 8'h00);

    rst = 1'b1;
    @(negedge clk);

    foreach (tv[i]) begin
      car_arrive = tv[i].arr;
      car_exit   = tv[i].ex;
      exit_from  = tv[i].from;
      alarm_clr  = tv[i].clr;
      case (tv[i].csel)
        1:       exit_code = mcode[tv[i].from];
        2:       exit_code = mcode[tv[i].from] ^ 8'h01;
        default: exit_code = tv[i].code;
      endcase
      exp_tk = m_lfsr;
      @(negedge clk);
      tag = $sformatf("vec%0d", i);
      chk({tag, " park_valid"}, 32'(park_valid), 32'(tv[i].pv));
      chk({tag, " exit_ok"}, 32'(exit_ok), 32'(tv[i].ok));
      chk({tag, " exit_err"}, 32'(exit_err), 32'(tv[i].err));
      check_status(tag, tv[i].alm, tv[i].rg);
      if (tv[i].pv) begin
        chk({tag, " slot"}, 32'(parking_slot), 32'(tv[i].slot));
        chk({tag, " ticket"}, 32'(ticket_code), 32'(exp_tk));
        mcode[tv[i].slot] = exp_tk;
      end
    end

    // Arrival level held for 10 cycles grants exactly once (slot 2).
    car_arrive = 1'b1;
    exp_tk = m_lfsr;
    n_pv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (park_valid) begin
        n_pv++;
        chk("held slot", 32'(parking_slot), 2);
        chk("held ticket", 32'(ticket_code), 32'(exp_tk));
      end
    end
    chk("held grant count", 32'(n_pv), 1);
    check_status("held", 0, 8'hF7);
    car_arrive = 1'b0;
    @(negedge clk);

    // Reset between an arrival edge and its grant drops the grant.
    car_arrive = 1'b1;
    #2 rst = 1'b0;
    #1 chk("midreset register async", 32'(parking_register), 0);
    car_arrive = 1'b0;
    @(negedge clk);
    chk("midreset park_valid", 32'(park_valid), 0);
    chk("midreset slot", 32'(parking_slot), 0);
    chk("midreset ticket", 32'(ticket_code), 0);
    check_status("midreset", 0, 8'h00);

    // No request is taken on the first clock after release.
    rst = 1'b1;
    car_arrive = 1'b1;
    @(negedge clk);
    chk("release first clk park_valid", 32'(park_valid), 0);
    check_status("release", 0, 8'h00);
    car_arrive = 1'b0;
    @(negedge clk);
    car_arrive = 1'b1;
    exp_tk = m_lfsr;
    @(negedge clk);
    chk("post-reset park_valid", 32'(park_valid), 1);
    chk("post-reset slot", 32'(parking_slot), 0);
    chk("post-reset ticket", 32'(ticket_code), 32'(exp_tk));
    check_status("post-reset", 0, 8'h01);
    car_arrive = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
